// File: rtl/sc_ram_pkg.sv
// Shared types and helpers for the byte-enabled single-clock RAM and its clear engine.
package sc_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  function automatic int nb(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/sc_ram_be_if.sv
// Port A write / port B read bus plus clear handshake for sc_ram_be.
interface sc_ram_be_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NB         = 2
);
  logic                  ena;
  logic [NB-1:0]         wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dia;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dob;
  logic                  dob_valid;
  logic                  clear_req;
  logic                  ready;

  modport master (
    output ena, wea, addra, dia, enb, addrb, clear_req,
    input  dob, dob_valid, ready
  );

  modport slave (
    input  ena, wea, addra, dia, enb, addrb, clear_req,
    output dob, dob_valid, ready
  );
endinterface

// File: rtl/sc_ram_clear.sv
// Clear engine: walks every address once after reset or on request, then idles in RUN.
module sc_ram_clear
  import sc_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  clr_active,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  clr_state_e            state_r;
  clr_state_e            state_next;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic                  ready_r;

  // Next-state and counter logic; clear_req while clearing does not restart the walk.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_next = RUN;
          cnt_next   = {(ADDR_WIDTH + 1){1'b0}};
        end else begin
          cnt_next = cnt_r + 1'b1;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = {(ADDR_WIDTH + 1){1'b0}};
        end else begin
          cnt_next = cnt_r;
        end
      end
      default: begin
        state_next = RST_STATE;
        cnt_next   = {(ADDR_WIDTH + 1){1'b0}};
      end
    endcase
  end

  // ready is registered from the next state so it is low during reset in either mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RST_STATE;
      cnt_r   <= {(ADDR_WIDTH + 1){1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      ready_r <= (state_next == RUN);
    end
  end

  assign clr_active = (state_r == CLEAR);
  assign clr_addr   = cnt_r[ADDR_WIDTH-1:0];
  assign ready      = ready_r;

endmodule

// File: rtl/sc_ram_be.sv
// Single-clock dual-port RAM (A writes, B reads) with byte enables, 1/2-cycle read
// latency, selectable read-during-write behaviour and a hardware clear engine.
module sc_ram_be
  import sc_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic         clk,
  input logic         rst,
  sc_ram_be_if.slave  bus
);

  localparam int NB    = nb(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("sc_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic                  clr_active;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [NB-1:0]         wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [NB-1:0]         byp_lanes;
  logic [DATA_WIDTH-1:0] rd_next;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_v;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sc_ram_clear #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (bus.clear_req),
    .clr_active (clr_active),
    .clr_addr   (clr_addr),
    .ready      (bus.ready)
  );

  // While clearing, the engine owns the write port with all lanes enabled and zero data.
  always_comb begin
    if (clr_active) begin
      wr_en   = {NB{1'b1}};
      wr_addr = clr_addr;
      wr_data = {DATA_WIDTH{1'b0}};
    end else begin
      wr_en   = bus.ena ? bus.wea : {NB{1'b0}};
      wr_addr = bus.addra;
      wr_data = bus.dia;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en[i]) begin
        mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_en = bus.enb & ~clr_active;

  // Same-address bypass: only the lanes being written take the new data.
  always_comb begin
    if ((COLLISION_MODE == WRITE_FIRST) && bus.ena && (bus.addra == bus.addrb)) begin
      byp_lanes = bus.wea;
    end else begin
      byp_lanes = {NB{1'b0}};
    end
    rd_next = mem[bus.addrb];
    for (int i = 0; i < NB; i++) begin
      rd_next[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_lanes[i] ? bus.dia[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                         : mem[bus.addrb][i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= {DATA_WIDTH{1'b0}};
      rd_v <= 1'b0;
    end else begin
      rd_v <= rd_en;
      if (rd_en) begin
        rd_q <= rd_next;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.dob       = rd_q;
    assign bus.dob_valid = rd_v;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dob_r;
    logic                  dob_valid_r;

    // Second output stage; holds its value across idle slots like the first.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dob_r       <= {DATA_WIDTH{1'b0}};
        dob_valid_r <= 1'b0;
      end else begin
        dob_valid_r <= rd_v;
        if (rd_v) begin
          dob_r <= rd_q;
        end
      end
    end

    assign bus.dob       = dob_r;
    assign bus.dob_valid = dob_valid_r;
  end else begin : g_bad_latency
    $error("sc_ram_be: READ_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_sc_ram_be.sv
// Directed bench: three 16-deep instances (L1 read-first, L1 write-first, L2 read-first) share stimulus.
module tb_sc_ram_be;
  import sc_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [1:0]  wea = 2'b00;
  logic [3:0]  addra = 4'd0;
  logic [15:0] dia = 16'h0000;
  logic        enb = 1'b0;
  logic [3:0]  addrb = 4'd0;
  logic        clear_req = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sc_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NB(2)) b0 ();
  sc_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NB(2)) b1 ();
  sc_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NB(2)) b2 ();

  assign b0.ena = ena;  assign b0.wea = wea;  assign b0.addra = addra;  assign b0.dia = dia;
  assign b0.enb = enb;  assign b0.addrb = addrb;  assign b0.clear_req = clear_req;
  assign b1.ena = ena;  assign b1.wea = wea;  assign b1.addra = addra;  assign b1.dia = dia;
  assign b1.enb = enb;  assign b1.addrb = addrb;  assign b1.clear_req = clear_req;
  assign b2.ena = ena;  assign b2.wea = wea;  assign b2.addra = addra;  assign b2.dia = dia;
  assign b2.enb = enb;  assign b2.addrb = addrb;  assign b2.clear_req = clear_req;

  sc_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(1),
              .COLLISION_MODE(READ_FIRST), .CLEAR_ON_RESET(1)) d0 (.clk(clk), .rst(rst), .bus(b0));
  sc_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(1),
              .COLLISION_MODE(WRITE_FIRST), .CLEAR_ON_RESET(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  sc_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(2),
              .COLLISION_MODE(READ_FIRST), .CLEAR_ON_RESET(1)) d2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic        ena;
    logic [1:0]  wea;
    logic [3:0]  addra;
    logic [15:0] dia;
    logic        enb;
    logic [3:0]  addrb;
    logic        chk_data;
    logic        exp_valid;
    logic [15:0] exp_rf;
    logic [15:0] exp_wf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (b0.ready !== 1'b1 && n < 40);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready0"}, {31'd0, b0.ready}, 32'd0);
    check({tag, "_ready1"}, {31'd0, b1.ready}, 32'd0);
    check({tag, "_ready2"}, {31'd0, b2.ready}, 32'd0);
    check({tag, "_valid0"}, {31'd0, b0.dob_valid}, 32'd0);
    check({tag, "_valid2"}, {31'd0, b2.dob_valid}, 32'd0);
    check({tag, "_dob0"}, {16'd0, b0.dob}, 32'd0);
    check({tag, "_dob2"}, {16'd0, b2.dob}, 32'd0);
  endtask

  initial begin
    int n;
    int low;
    logic [15:0] v;

    // Vector table: post-reset reads of every address, byte lanes, collisions, hold.
    for (int a = 0; a < 16; a++) begin
      vecs.push_back('{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'(a), 1'b1, 1'b1, 16'h0000, 16'h0000});
    end
    vecs.push_back('{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 2'b01, 4'd3, 16'h12FF, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b1, 16'hABFF, 16'hABFF});
    vecs.push_back('{1'b1, 2'b11, 4'd5, 16'h1111, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 2'b10, 4'd5, 16'h2222, 1'b1, 4'd5, 1'b1, 1'b1, 16'h1111, 16'h2211});
    vecs.push_back('{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 1'b1, 16'h2211, 16'h2211});
    vecs.push_back('{1'b1, 2'b00, 4'd5, 16'hFFFF, 1'b1, 4'd5, 1'b1, 1'b1, 16'h2211, 16'h2211});
    for (int a = 1; a <= 4; a++) begin
      vecs.push_back('{1'b1, 2'b11, 4'(a), 16'h1001 * 16'(a), 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0});
    end
    vecs.push_back('{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0, 16'h2211, 16'h2211});

    step();
    step();
    check_idle_outputs("reset");

    rst = 1'b0;
    wait_ready(n);
    check("reset_clear_cycles", n, 16);
    check("reset_clear_ready2", {31'd0, b2.ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      ena = vecs[i].ena;  wea = vecs[i].wea;  addra = vecs[i].addra;  dia = vecs[i].dia;
      enb = vecs[i].enb;  addrb = vecs[i].addrb;
      step();
      check($sformatf("vec%0d_valid_rf", i), {31'd0, b0.dob_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_valid_wf", i), {31'd0, b1.dob_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_dob_rf", i), {16'd0, b0.dob}, {16'd0, vecs[i].exp_rf});
        check($sformatf("vec%0d_dob_wf", i), {16'd0, b1.dob}, {16'd0, vecs[i].exp_wf});
      end
    end
    ena = 1'b0;
    wea = 2'b00;

    // Back-to-back reads of addrs 1..4: L1 valid on edges 1..4, L2 on edges 2..5.
    for (int s = 0; s < 7; s++) begin
      if (s < 4) begin
        enb = 1'b1;
        addrb = 4'(s + 1);
      end else begin
        enb = 1'b0;
      end
      step();
      check($sformatf("lat2_valid_s%0d", s), {31'd0, b2.dob_valid}, {31'd0, (s >= 1 && s <= 4)});
      if (s >= 1 && s <= 4) begin
        v = 16'h1001 * 16'(s);
        check($sformatf("lat2_dob_s%0d", s), {16'd0, b2.dob}, {16'd0, v});
      end
      check($sformatf("lat1_valid_s%0d", s), {31'd0, b0.dob_valid}, {31'd0, (s < 4)});
      if (s < 4) begin
        v = 16'h1001 * 16'(s + 1);
        check($sformatf("lat1_dob_s%0d", s), {16'd0, b0.dob}, {16'd0, v});
      end
    end

    for (int a = 0; a < 16; a++) begin
      ena = 1'b1;  wea = 2'b11;  addra = 4'(a);  dia = 16'h5A5A;
      step();
    end
    ena = 1'b0;
    enb = 1'b1;
    addrb = 4'd10;
    step();
    enb = 1'b0;
    check("fill_dob", {16'd0, b0.dob}, {16'd0, 16'h5A5A});

    // Requested clear with port traffic and a second clear_req mid-way, both ignored.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clr_ready_drop", {31'd0, b0.ready}, 32'd0);
    low = 1;
    ena = 1'b1;  wea = 2'b11;  addra = 4'd7;  dia = 16'hBEEF;
    enb = 1'b1;  addrb = 4'd7;
    for (int k = 0; k < 40; k++) begin
      clear_req = (k == 5);
      step();
      check($sformatf("clr_valid0_k%0d", k), {31'd0, b0.dob_valid}, 32'd0);
      check($sformatf("clr_valid2_k%0d", k), {31'd0, b2.dob_valid}, 32'd0);
      if (b0.ready === 1'b1) break;
      low++;
    end
    ena = 1'b0;
    enb = 1'b0;
    clear_req = 1'b0;
    check("clr_ready_low_cycles", low, 16);

    for (int a = 0; a < 16; a++) begin
      enb = 1'b1;
      addrb = 4'(a);
      step();
      check($sformatf("postclr_valid_a%0d", a), {31'd0, b0.dob_valid}, 32'd1);
      check($sformatf("postclr_dob_rf_a%0d", a), {16'd0, b0.dob}, 32'd0);
      check($sformatf("postclr_dob_wf_a%0d", a), {16'd0, b1.dob}, 32'd0);
    end
    enb = 1'b0;

    // Reset during a clear (counter at 7) with read data still on the outputs.
    ena = 1'b1;  wea = 2'b11;  addra = 4'd9;  dia = 16'h9999;
    step();
    ena = 1'b0;
    enb = 1'b1;  addrb = 4'd9;  clear_req = 1'b1;
    step();
    enb = 1'b0;
    clear_req = 1'b0;
    check("rstmid_pre_dob", {16'd0, b0.dob}, {16'd0, 16'h9999});
    check("rstmid_pre_valid", {31'd0, b0.dob_valid}, 32'd1);
    repeat (7) step();
    check("rstmid_pre_dob2", {16'd0, b2.dob}, {16'd0, 16'h9999});
    rst = 1'b1;
    #1;
    check_idle_outputs("rstmid");
    step();
    step();
    rst = 1'b0;
    wait_ready(n);
    check("rstmid_clear_cycles", n, 16);
    enb = 1'b1;
    addrb = 4'd9;
    step();
    enb = 1'b0;
    check("rstmid_addr9_valid", {31'd0, b0.dob_valid}, 32'd1);
    check("rstmid_addr9_dob", {16'd0, b0.dob}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
